// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: op-code encoding and
// default widths used by alu_core and alu_pipe.
package alu_pkg;

    localparam int ALU_OP_W  = 3;
    localparam int ALU_WIDTH = 8;

    typedef enum logic [ALU_OP_W-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_PSB = 3'b101,
        OP_ACC = 3'b110,
        OP_CLR = 3'b111
    } alu_op_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath; computes the result, flags and the
// accumulator value the op would leave behind.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_e          op,
    input  logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic [WIDTH-1:0] acc_next
);

    logic [WIDTH:0] sum_ab;
    logic [WIDTH:0] sum_acc;

    assign sum_ab  = {1'b0, a} + {1'b0, b};
    assign sum_acc = {1'b0, acc} + {1'b0, a};

    always_comb begin
        result   = '0;
        carry    = 1'b0;
        acc_next = acc;
        unique case (op)
            OP_ADD: begin
                result = sum_ab[WIDTH-1:0];
                carry  = sum_ab[WIDTH];
            end
            OP_SUB: begin
                result = a - b;
                carry  = (a < b);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_PSB: result = b;
            OP_ACC: begin
                result   = sum_acc[WIDTH-1:0];
                carry    = sum_acc[WIDTH];
                acc_next = sum_acc[WIDTH-1:0];
            end
            OP_CLR: begin
                result   = '0;
                acc_next = '0;
            end
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline: S1 holds the operands, S2 the
// registered result; the accumulator commits as an op moves S1 -> S2.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int OP_W  = ALU_OP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] ain,
    input  logic [WIDTH-1:0] bin,
    input  logic [OP_W-1:0]  sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] zout,
    output logic             cout,
    output logic             zero,
    output logic             out_valid,
    input  logic             out_ready
);

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    alu_op_e          op_q, op_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] zout_q, zout_d;
    logic             cout_q, cout_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    logic [WIDTH-1:0] core_result;
    logic             core_carry;
    logic             core_zero;
    logic [WIDTH-1:0] core_acc_next;

    logic s2_free;
    logic s1_adv;
    logic in_fire;

    assign s2_free  = !out_valid_q || out_ready;
    assign s1_adv   = s1_valid_q && s2_free;
    assign in_ready = !s1_valid_q || s1_adv;
    assign in_fire  = in_valid && in_ready;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a        (a_q),
        .b        (b_q),
        .op       (op_q),
        .acc      (acc_q),
        .result   (core_result),
        .carry    (core_carry),
        .zero     (core_zero),
        .acc_next (core_acc_next)
    );

    always_comb begin
        s1_valid_d  = s1_valid_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        out_valid_d = out_valid_q;
        zout_d      = zout_q;
        cout_d      = cout_q;
        zero_d      = zero_q;
        acc_d       = acc_q;

        if (in_fire) begin
            s1_valid_d = 1'b1;
            a_d        = ain;
            b_d        = bin;
            op_d       = alu_op_e'(sel);
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        // acc commits only here, so a stalled op cannot update it twice
        if (s1_adv) begin
            out_valid_d = 1'b1;
            zout_d      = core_result;
            cout_d      = core_carry;
            zero_d      = core_zero;
            acc_d       = core_acc_next;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= OP_ADD;
            out_valid_q <= 1'b0;
            zout_q      <= '0;
            cout_q      <= 1'b0;
            zero_q      <= 1'b1;
            acc_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            out_valid_q <= out_valid_d;
            zout_q      <= zout_d;
            cout_q      <= cout_d;
            zero_q      <= zero_d;
            acc_q       <= acc_d;
        end
    end

    assign out_valid = out_valid_q;
    assign zout      = zout_q;
    assign cout      = cout_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed and random bench for alu_pipe (WIDTH=8) with a
// transaction-level reference model and result scoreboard.
module tb_alu_pipe;

    typedef struct {
        int z;
        int c;
        int zr;
    } res_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ain, bin;
    logic [2:0] sel;
    logic       in_valid, in_ready;
    logic [7:0] zout;
    logic       cout, zero, out_valid, out_ready;

    int   checks = 0;
    int   errors = 0;
    int   m_acc  = 0;
    res_t exp_q[$];
    res_t log_q[$];
    int   n_in   = 0;
    int   n_out  = 0;
    bit   last_in_fire;
    bit   stalled = 1'b0;
    int   pz, pc, pzr;

    alu_pipe #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .ain       (ain),
        .bin       (bin),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .zout      (zout),
        .cout      (cout),
        .zero      (zero),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input int op, input int a, input int b,
                         output res_t r);
        int v;
        r.c = 0;
        case (op)
            0: begin v = a + b; r.c = int'(v > 255); end
            1: begin v = a - b; r.c = int'(a < b); end
            2: v = a & b;
            3: v = a | b;
            4: v = a ^ b;
            5: v = b;
            6: begin
                v = m_acc + a;
                r.c = int'(v > 255);
                m_acc = v % 256;
            end
            default: begin v = 0; m_acc = 0; end
        endcase
        r.z  = (v + 256) % 256;
        r.zr = int'(r.z == 0);
    endtask

    task automatic step();
        res_t r;
        bit   ofire;
        @(negedge clk);
        last_in_fire = in_valid && in_ready && !rst;
        ofire = out_valid && out_ready && !rst;
        if (!rst) begin
            chk("in_ready", int'(in_ready),
                int'(exp_q.size() < 2 || out_ready));
            if (exp_q.size() == 0) chk("idle_valid", int'(out_valid), 0);
            if (stalled) begin
                chk("hold_valid", int'(out_valid), 1);
                chk("hold_zout", int'(zout), pz);
                chk("hold_cout", int'(cout), pc);
                chk("hold_zero", int'(zero), pzr);
            end
            if (ofire && exp_q.size() > 0) begin
                r = exp_q.pop_front();
                chk("sb_zout", int'(zout), r.z);
                chk("sb_cout", int'(cout), r.c);
                chk("sb_zero", int'(zero), r.zr);
                log_q.push_back('{int'(zout), int'(cout), int'(zero)});
                n_out++;
            end
            if (last_in_fire) begin
                model(int'(sel), int'(ain), int'(bin), r);
                exp_q.push_back(r);
                n_in++;
            end
            stalled = out_valid && !out_ready;
            pz  = int'(zout);
            pc  = int'(cout);
            pzr = int'(zero);
        end
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            m_acc   = 0;
            stalled = 1'b0;
        end
        #1;
    endtask

    task automatic send(input int op, input int a, input int b);
        bit got = 1'b0;
        sel = 3'(op);
        ain = 8'(a);
        bin = 8'(b);
        in_valid = 1'b1;
        for (int t = 0; t < 50 && !got; t++) begin
            step();
            got = last_in_fire;
        end
        if (!got) chk("send_timeout", int'(got), 1);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 20 && (exp_q.size() > 0 || out_valid); t++)
            step();
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic chk_log(input int i, input int z, input int c,
                           input int zr);
        if (i < log_q.size()) begin
            chk("log_zout", log_q[i].z, z);
            chk("log_cout", log_q[i].c, c);
            chk("log_zero", log_q[i].zr, zr);
        end else begin
            chk("log_missing", log_q.size(), i + 1);
        end
    endtask

    initial begin
        int k;
        rst = 1'b1; ain = '0; bin = '0; sel = '0;
        in_valid = 1'b0; out_ready = 1'b1;
        step(); step();
        rst = 1'b0;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_zout", int'(zout), 0);
        chk("rst_cout", int'(cout), 0);
        chk("rst_zero", int'(zero), 1);
        chk("rst_ready", int'(in_ready), 1);

        // ADD with carry-out and two-register latency
        log_q.delete();
        send(0, 'hF0, 'h20);
        in_valid = 1'b0;
        chk("lat_s1", int'(out_valid), 0);
        step();
        chk("lat_s2", int'(out_valid), 1);
        chk("add_zout", int'(zout), 'h10);
        chk("add_cout", int'(cout), 1);
        chk("add_zero", int'(zero), 0);
        drain();

        // SUB equal and borrow
        log_q.delete();
        send(1, 5, 5);
        send(1, 3, 4);
        drain();
        chk_log(0, 'h00, 0, 1);
        chk_log(1, 'hFF, 1, 0);

        // back-to-back accumulator chain
        log_q.delete();
        send(7, 0, 0);
        send(6, 'h80, 0);
        send(6, 'h80, 0);
        send(6, 'h01, 0);
        drain();
        chk_log(0, 'h00, 0, 1);
        chk_log(1, 'h80, 0, 0);
        chk_log(2, 'h00, 1, 1);
        chk_log(3, 'h01, 0, 0);

        // backpressure: five ADDs, output stalled for four cycles
        log_q.delete();
        k = 0;
        out_ready = 1'b0;
        in_valid = 1'b1;
        sel = 3'd0; ain = 8'h01; bin = 8'h00;
        repeat (4) begin
            step();
            if (last_in_fire) begin
                k++;
                ain = 8'(16 * k + 1);
                bin = 8'(k);
            end
        end
        chk("stall_accepted", k, 2);
        chk("stall_ready", int'(in_ready), 0);
        out_ready = 1'b1;
        for (int i = k; i < 5; i++) send(0, 16 * i + 1, i);
        drain();
        chk("stall_count", log_q.size(), 5);
        for (int i = 0; i < 5; i++) chk_log(i, 17 * i + 1, 0, 0);

        // reset with two ACC ops buffered
        log_q.delete();
        out_ready = 1'b0;
        send(6, 1, 0);
        send(6, 2, 0);
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_zero", int'(zero), 1);
        chk("mid_rst_zout", int'(zout), 0);
        chk("mid_rst_ready", int'(in_ready), 1);
        out_ready = 1'b1;
        send(6, 7, 0);
        drain();
        chk("mid_rst_count", log_q.size(), 1);
        chk_log(0, 'h07, 0, 0);

        // random stream against the model
        n_in = 0;
        n_out = 0;
        for (int n = 0; n < 400; n++) begin
            sel       = 3'($urandom_range(0, 7));
            ain       = 8'($urandom);
            bin       = 8'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        drain();
        chk("rand_count", n_out, n_in);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
